bram_stream_reader: RTL and testbench

Read-side engine for the dual-port 8-bit × 60 block RAM used by the BRAM pattern writer. On a start command it fetches a run of words from the RAM read port, including wrap past the last address, and presents them as a valid/ready stream with a last-beat marker. It absorbs the RAM's fixed read latency and downstream backpressure without losing or duplicating words. It sits between the BRAM port B and any consumer (checker, UART tx, DMA).

---
 rtl/bram_pkg.sv | 14 +
 rtl/bram_rd_fifo.sv | 57 +++++
 rtl/bram_stream_reader.sv | 151 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants and types for the BRAM pattern writer/reader pair.
package bram_pkg;

   localparam int unsigned DEPTH  = 60;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 6;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDrain
   } rd_state_e;

endpackage

// File: rtl/bram_rd_fifo.sv
// Show-ahead FIFO between the BRAM read pipeline and the output stream.
// Head entry is visible on rdata_o whenever valid_o is high.
module bram_rd_fifo #(
   parameter int unsigned Width = 9,
   parameter int unsigned Depth = 4,
   parameter int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic             clka,
   input  logic             rsta,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             valid_o,
   output logic [CntW-1:0]  count_o
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop  = pop_i && (cnt_q != '0);
      do_push = push_i && ((cnt_q != CntW'(Depth)) || do_pop);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (do_push) begin
         wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (do_push) mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign valid_o = (cnt_q != '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Fetches a run of BRAM words (wrapping at DEPTH) and streams them out as valid/ready
// with a last marker, using credit-based issue so the output FIFO never overflows.
module bram_stream_reader #(
   parameter int unsigned DATA_W     = bram_pkg::DATA_W,
   parameter int unsigned ADDR_W     = bram_pkg::ADDR_W,
   parameter int unsigned DEPTH      = bram_pkg::DEPTH,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last
);
   import bram_pkg::*;

   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   rd_state_e         state_q, state_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
   logic              bram_en_q, bram_en_d;
   logic              tag_last_q, tag_last_d;
   logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
   logic [RD_LAT-1:0] last_sr_q, last_sr_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [CntW-1:0]   fifo_cnt;
   logic              pop, can_issue;
   logic [7:0]        outst;

   assign pop = m_valid && m_ready;

   // Outstanding = issued-but-unpopped words; a word popping this cycle frees its slot now.
   always_comb begin
      outst = 8'(fifo_cnt) + 8'(bram_en_q);
      for (int i = 0; i < RD_LAT; i++) outst = outst + 8'(vld_sr_q[i]);
      if (pop) outst = outst - 8'd1;
      can_issue = (outst < 8'(FIFO_DEPTH));
   end

   always_comb begin
      vld_sr_d[0]  = bram_en_q;
      last_sr_d[0] = tag_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_sr_d[i]  = vld_sr_q[i-1];
         last_sr_d[i] = last_sr_q[i-1];
      end
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      bram_addr_d = bram_addr_q;
      bram_en_d   = 1'b0;
      tag_last_d  = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if ((len == '0) || (len > (ADDR_W+1)'(DEPTH)) ||
                   ({1'b0, start_addr} >= (ADDR_W+1)'(DEPTH))) begin
                  err_d = 1'b1;
               end else begin
                  bram_en_d   = 1'b1;
                  bram_addr_d = start_addr;
                  rem_d       = len - 1'b1;
                  tag_last_d  = (len == (ADDR_W+1)'(1));
                  state_d     = (len == (ADDR_W+1)'(1)) ? StDrain : StRead;
               end
            end
         end
         StRead: begin
            if (can_issue) begin
               bram_en_d   = 1'b1;
               bram_addr_d = (bram_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : bram_addr_q + 1'b1;
               rem_d       = rem_q - 1'b1;
               if (rem_q == (ADDR_W+1)'(1)) begin
                  tag_last_d = 1'b1;
                  state_d    = StDrain;
               end
            end
         end
         StDrain: begin
            if (pop && m_last) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         state_q     <= StIdle;
         rem_q       <= '0;
         bram_addr_q <= '0;
         bram_en_q   <= 1'b0;
         tag_last_q  <= 1'b0;
         vld_sr_q    <= '0;
         last_sr_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         bram_addr_q <= bram_addr_d;
         bram_en_q   <= bram_en_d;
         tag_last_q  <= tag_last_d;
         vld_sr_q    <= vld_sr_d;
         last_sr_q   <= last_sr_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   bram_rd_fifo #(
      .Width (DATA_W + 1),
      .Depth (FIFO_DEPTH),
      .CntW  (CntW)
   ) u_fifo (
      .clka    (clka),
      .rsta    (rsta),
      .push_i  (vld_sr_q[RD_LAT-1]),
      .wdata_i ({last_sr_q[RD_LAT-1], bram_dout}),
      .pop_i   (pop),
      .rdata_o ({m_last, m_data}),
      .valid_o (m_valid),
      .count_o (fifo_cnt)
   );

   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign err       = err_q;
   assign bram_en   = bram_en_q;
   assign bram_addr = bram_addr_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: RD_LAT=1 and RD_LAT=2 instances, each with a
// behavioural RAM holding word i = 3+2i.
module tb_bram_stream_reader;

   logic       clka = 1'b0;
   logic       rsta;
   logic       start1, start2;
   logic [5:0] start_addr;
   logic [6:0] len;
   logic       m_ready1, m_ready2;

   logic       busy1, done1, err1, en1, mv1, ml1;
   logic [5:0] addr1;
   logic [7:0] dout1, md1;
   logic       busy2, done2, err2, en2, mv2, ml2;
   logic [5:0] addr2;
   logic [7:0] dout2, md2, r2a;

   logic [7:0] mem [60];
   int         cyc = 0;
   int         nvec = 0;
   int         nerr = 0;

   logic [8:0] exp1 [$];
   logic [8:0] exp2 [$];
   logic [5:0] addr_q [$];

   always #5 clka = ~clka;
   always @(posedge clka) cyc <= cyc + 1;

   initial for (int i = 0; i < 60; i++) mem[i] = 8'(3 + 2 * i);

   always @(posedge clka) begin
      if (en1) dout1 <= mem[addr1];
      if (en2) r2a <= mem[addr2];
      dout2 <= r2a;
   end

   bram_stream_reader #(.RD_LAT(1), .FIFO_DEPTH(4)) dut1 (
      .clka(clka), .rsta(rsta), .start(start1), .start_addr(start_addr), .len(len),
      .busy(busy1), .done(done1), .err(err1), .bram_en(en1), .bram_addr(addr1),
      .bram_dout(dout1), .m_valid(mv1), .m_ready(m_ready1), .m_data(md1), .m_last(ml1)
   );

   bram_stream_reader #(.RD_LAT(2), .FIFO_DEPTH(4)) dut2 (
      .clka(clka), .rsta(rsta), .start(start2), .start_addr(start_addr), .len(len),
      .busy(busy2), .done(done2), .err(err2), .bram_en(en2), .bram_addr(addr2),
      .bram_dout(dout2), .m_valid(mv2), .m_ready(m_ready2), .m_data(md2), .m_last(ml2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_run(input int k, input int a, input int l);
      for (int i = 0; i < l; i++) begin
         int ad;
         logic [8:0] e;
         ad = (a + i) % 60;
         e  = {(i == l - 1), 8'(3 + 2 * ad)};
         if (k == 1) begin
            exp1.push_back(e);
            addr_q.push_back(6'(ad));
         end else begin
            exp2.push_back(e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic wait_last(input int k, output int t);
      t = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clka);
         if (k == 1 ? (mv1 && m_ready1 && ml1) : (mv2 && m_ready2 && ml2)) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk("last_beat_timeout", 32'(0), 32'(1));
   endtask

   // dut1 monitor: read addresses, credit bound, stall stability, beat data
   initial begin
      int issued, accepted;
      logic       stall_prev;
      logic [7:0] stall_data;
      issued = 0; accepted = 0; stall_prev = 1'b0; stall_data = '0;
      forever begin
         @(negedge clka);
         if (!rsta) begin
            issued = 0; accepted = 0; stall_prev = 1'b0;
         end else begin
            if (en1) begin
               issued++;
               if (addr_q.size() == 0) chk("rd_addr_unexpected", 32'(addr1), 32'hFFFF_FFFF);
               else chk("rd_addr", 32'(addr1), 32'(addr_q.pop_front()));
               chk("credit_bound", 32'(issued - accepted <= 4), 32'(1));
            end
            if (stall_prev) chk("stall_hold", 32'({mv1, md1}), 32'({1'b1, stall_data}));
            if (mv1 && m_ready1) begin
               accepted++;
               if (exp1.size() == 0) chk("beat1_unexpected", 32'({ml1, md1}), 32'hFFFF_FFFF);
               else chk("beat1", 32'({ml1, md1}), 32'(exp1.pop_front()));
            end
            stall_prev = mv1 && !m_ready1;
            stall_data = md1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clka);
         if (rsta && mv2 && m_ready2) begin
            if (exp2.size() == 0) chk("beat2_unexpected", 32'({ml2, md2}), 32'hFFFF_FFFF);
            else chk("beat2", 32'({ml2, md2}), 32'(exp2.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t0, t;
      logic [5:0] rj_addr [3];
      logic [6:0] rj_len [3];
      rj_addr[0] = 6'd0;  rj_len[0] = 7'd0;
      rj_addr[1] = 6'd0;  rj_len[1] = 7'd61;
      rj_addr[2] = 6'd60; rj_len[2] = 7'd1;

      rsta = 1'b0; start1 = 1'b0; start2 = 1'b0; start_addr = '0; len = '0;
      m_ready1 = 1'b1; m_ready2 = 1'b1;
      repeat (3) tick();
      @(negedge clka);
      chk("reset_outs1", 32'({busy1, done1, err1, en1, addr1, mv1, md1, ml1}), 32'(0));
      chk("reset_outs2", 32'({busy2, done2, err2, en2, addr2, mv2, md2, ml2}), 32'(0));
      tick();
      rsta = 1'b1;
      repeat (2) tick();

      // Full 60-word run, RD_LAT=1
      start1 = 1'b1; start_addr = 6'd0; len = 7'd60;
      push_run(1, 0, 60);
      t0 = cyc;
      tick();
      start1 = 1'b0;
      @(negedge clka);
      chk("s1_c1_busy_en_mv", 32'({busy1, en1, mv1}), 32'(3'b110));
      tick();
      @(negedge clka);
      chk("s1_c2_mvalid", 32'(mv1), 32'(0));
      tick();
      @(negedge clka);
      chk("s1_c3_mvalid", 32'(mv1), 32'(1));
      wait_last(1, t);
      chk("s1_last_cycle", 32'(t - t0), 32'(62));

      // Wrap run, started in the done cycle of the previous run
      tick();
      start1 = 1'b1; start_addr = 6'd58; len = 7'd4;
      push_run(1, 58, 4);
      t0 = cyc;
      @(negedge clka);
      chk("s1_done_busy", 32'({done1, busy1}), 32'(2'b10));
      tick();
      start1 = 1'b0;
      @(negedge clka);
      chk("s2_accept_in_done_cycle", 32'({done1, busy1}), 32'(2'b01));
      wait_last(1, t);
      chk("s2_last_cycle", 32'(t - t0), 32'(6));
      @(negedge clka);
      chk("s2_done_busy", 32'({done1, busy1}), 32'(2'b10));

      // Backpressure: toggling ready, then a long stall
      tick();
      start1 = 1'b1; start_addr = 6'd5; len = 7'd10;
      push_run(1, 5, 10);
      m_ready1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         start1 = 1'b0;
         m_ready1 = ~m_ready1;
      end
      m_ready1 = 1'b0;
      repeat (8) tick();
      @(negedge clka);
      chk("s3_credit_stall", 32'({en1, mv1, busy1}), 32'(3'b011));
      tick();
      m_ready1 = 1'b1;
      wait_last(1, t);
      @(negedge clka);
      chk("s3_done_busy", 32'({done1, busy1}), 32'(2'b10));
      tick();
      chk("s3_all_beats", 32'(exp1.size()), 32'(0));

      // Rejected commands
      for (int i = 0; i < 3; i++) begin
         tick();
         start1 = 1'b1; start_addr = rj_addr[i]; len = rj_len[i];
         tick();
         start1 = 1'b0;
         @(negedge clka);
         chk("s4_err_pulse", 32'({err1, busy1, en1}), 32'(3'b100));
         tick();
         @(negedge clka);
         chk("s4_err_single", 32'({err1, busy1, en1}), 32'(3'b000));
      end

      // Ignored restart, then reset mid-run
      tick();
      start1 = 1'b1; start_addr = 6'd0; len = 7'd20;
      push_run(1, 0, 20);
      tick();
      start1 = 1'b0;
      tick();
      start1 = 1'b1; start_addr = 6'd30; len = 7'd5;
      tick();
      start1 = 1'b0;
      @(negedge clka);
      chk("s5_ignored_start_no_err", 32'({err1, busy1}), 32'(2'b01));
      tick();
      tick();
      rsta = 1'b0;
      @(negedge clka);
      chk("s5_reset_outs", 32'({busy1, done1, err1, en1, addr1, mv1, md1, ml1}), 32'(0));
      tick();
      @(negedge clka);
      chk("s5_reset_outs_held", 32'({busy1, done1, err1, en1, addr1, mv1, md1, ml1}), 32'(0));
      exp1.delete();
      addr_q.delete();
      tick();
      rsta = 1'b1;
      tick();
      start1 = 1'b1; start_addr = 6'd0; len = 7'd2;
      push_run(1, 0, 2);
      tick();
      start1 = 1'b0;
      wait_last(1, t);
      @(negedge clka);
      chk("s5_post_reset_done", 32'({done1, busy1}), 32'(2'b10));

      // Full run again with RD_LAT=2
      tick();
      start2 = 1'b1; start_addr = 6'd0; len = 7'd60;
      push_run(2, 0, 60);
      t0 = cyc;
      tick();
      start2 = 1'b0;
      @(negedge clka);
      chk("s6_c1_busy_en", 32'({busy2, en2}), 32'(2'b11));
      tick();
      tick();
      @(negedge clka);
      chk("s6_c3_mvalid", 32'(mv2), 32'(0));
      tick();
      @(negedge clka);
      chk("s6_c4_mvalid", 32'(mv2), 32'(1));
      wait_last(2, t);
      chk("s6_last_cycle", 32'(t - t0), 32'(63));
      @(negedge clka);
      chk("s6_done_busy", 32'({done2, busy2}), 32'(2'b10));

      tick();
      chk("end_exp1_empty", 32'(exp1.size()), 32'(0));
      chk("end_exp2_empty", 32'(exp2.size()), 32'(0));
      chk("end_addr_empty", 32'(addr_q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
